// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate-multiplier arbiter.
//
// Contents:
//   OPW / PW   operand and product widths
//   TRUNC_L    truncation column of the approximate core: partial-product bits in
//              columns below TRUNC_L are never generated
//   MAX_IDW    widest tag the result record can carry (NREQ <= 8)
//   op_t       operand bundle (x, y, exact)
//   res_t      result record (z, id)
//   keep_mask  per-row mask of partial-product bits kept by the core
package approx_mul_pkg;

  localparam int unsigned OPW     = 8;
  localparam int unsigned PW      = 16;
  localparam int unsigned TRUNC_L = 6;
  localparam int unsigned MAX_IDW = 3;

  typedef struct packed {
    logic [OPW-1:0] x;
    logic [OPW-1:0] y;
    logic           exact;
  } op_t;

  typedef struct packed {
    logic [PW-1:0]      z;
    logic [MAX_IDW-1:0] id;
  } res_t;

  // Row j of the partial-product array keeps x[i] only where column i+j >= TRUNC_L.
  function automatic logic [OPW-1:0] keep_mask(input int unsigned j);
    logic [OPW-1:0] m;
    for (int unsigned i = 0; i < OPW; i++) begin
      m[i] = ((i + j) >= TRUNC_L);
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_mul_core.sv
// Combinational unsigned 8x8 truncated (approximate) multiplier, l = 6.
//
// Every partial-product bit x[i]&y[j] with i+j < 6 is dropped; all remaining
// bits are summed exactly, so z <= x*y and z == x*y whenever the operands have
// no set bits that meet in the low six columns.
//
// Ports:
//   x  in  8   multiplicand
//   y  in  8   multiplier
//   z  out 16  approximate product
module approx_mul_core
  import approx_mul_pkg::*;
(
  input  logic [OPW-1:0] x,
  input  logic [OPW-1:0] y,
  output logic [PW-1:0]  z
);

  logic [OPW-1:0] row;

  always_comb begin
    z   = '0;
    row = '0;
    for (int unsigned j = 0; j < OPW; j++) begin
      row = y[j] ? (x & keep_mask(j)) : '0;
      z   = z + (PW'(row) << j);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with wrap at NREQ (not at 2^IDW).
//
// The grant is purely combinational on the current request vector: the first
// requester at or after ptr (wrapping NREQ-1 -> 0) wins, but only while adv is
// high. On a grant to g the pointer moves to g+1 mod NREQ; otherwise it holds.
//
// Ports:
//   clk      in  1     clock, rising edge
//   rst      in  1     asynchronous active-high reset (ptr -> 0)
//   req      in  NREQ  request vector
//   adv      in  1     downstream can accept an operand this cycle
//   gnt      out NREQ  one-hot grant, zero when nothing is granted
//   gnt_idx  out IDW   index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  localparam logic [IDW:0]   NreqW = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LastIdx = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   cand;
  logic           found;

  // One extra bit on cand so ptr+k never overflows before the mod-NREQ fold.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= NreqW) begin
        cand = cand - NreqW;
      end
      if (adv && !found && req[cand[IDW-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IDW-1:0]]    = 1'b1;
        gnt_idx               = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/approx_mul_arbiter.sv
// Shares one approximate 8x8 multiplier among NREQ requesters.
//
// Round-robin grant, two registered stages (S1 operands, S2 result), tagged
// results with valid/ready backpressure. Grant cycle to res_valid is 2 cycles;
// one result per cycle while res_ready stays high. Reset discards in-flight work.
//
// Build option: define EXACT_BYPASS_EN to honour req_exact. When set, a request
// flagged exact gets the true 16-bit product; otherwise req_exact is ignored,
// the exact bit is not stored and no exact multiplier exists.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   tag width, must equal $clog2(NREQ)
//
// Ports:
//   clk        in  1        clock, rising edge
//   rst        in  1        asynchronous active-high reset
//   req_valid  in  NREQ     per-requester operand valid
//   req_ready  out NREQ     per-requester grant (one-hot or zero)
//   req_x      in  NREQ*8   packed multiplicands, requester i at [8i+7:8i]
//   req_y      in  NREQ*8   packed multipliers
//   req_exact  in  NREQ     per-requester exact-mode request
//   res_valid  out 1        result valid
//   res_ready  in  1        result consumer ready
//   res_z      out 16       product
//   res_id     out IDW      requester that issued the result
//   busy       out 1        any pipeline stage occupied
module approx_mul_arbiter
  import approx_mul_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_x,
  input  logic [NREQ*OPW-1:0] req_y,
  input  logic [NREQ-1:0]     req_exact,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PW-1:0]       res_z,
  output logic [IDW-1:0]      res_id,
  output logic                busy
);

  // Stall chain: S2 frees when empty or draining; S1 frees when empty or S2 frees.
  logic adv1, adv2;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_valid;
  op_t             gnt_op;

  logic            v1_q, v1_d;
  logic [OPW-1:0]  s1_x_q, s1_x_d;
  logic [OPW-1:0]  s1_y_q, s1_y_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;

  res_t            res_q, res_d;
  logic            res_valid_q, res_valid_d;

  logic [PW-1:0]   core_z;
  logic [PW-1:0]   s2_z;

  assign adv2 = !res_valid_q || res_ready;
  assign adv1 = !v1_q || adv2;

  // Gating with rst keeps req_ready low (and ptr frozen) while reset is held.
  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .adv     (adv1 && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_valid = |gnt;
  assign req_ready = gnt;

  // One-hot operand mux.
  always_comb begin
    gnt_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_op.x = req_x[i*OPW +: OPW];
        gnt_op.y = req_y[i*OPW +: OPW];
`ifdef EXACT_BYPASS_EN
        gnt_op.exact = req_exact[i];
`endif
      end
    end
  end

  // S1: operand register.
  always_comb begin
    v1_d    = v1_q;
    s1_x_d  = s1_x_q;
    s1_y_d  = s1_y_q;
    s1_id_d = s1_id_q;
    if (adv1) begin
      v1_d = gnt_valid;
      if (gnt_valid) begin
        s1_x_d  = gnt_op.x;
        s1_y_d  = gnt_op.y;
        s1_id_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      s1_x_q  <= '0;
      s1_y_q  <= '0;
      s1_id_q <= '0;
    end else begin
      v1_q    <= v1_d;
      s1_x_q  <= s1_x_d;
      s1_y_q  <= s1_y_d;
      s1_id_q <= s1_id_d;
    end
  end

  approx_mul_core u_core (
    .x (s1_x_q),
    .y (s1_y_q),
    .z (core_z)
  );

`ifdef EXACT_BYPASS_EN
  // The exact bit rides alongside the tag in S1.
  logic s1_exact_q, s1_exact_d;

  always_comb begin
    s1_exact_d = s1_exact_q;
    if (adv1 && gnt_valid) begin
      s1_exact_d = gnt_op.exact;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_exact_q <= 1'b0;
    end else begin
      s1_exact_q <= s1_exact_d;
    end
  end

  assign s2_z = s1_exact_q ? (PW'(s1_x_q) * PW'(s1_y_q)) : core_z;
`else
  logic unused_exact;
  assign unused_exact = ^{req_exact, gnt_op.exact};
  assign s2_z         = core_z;
`endif

  // S2: output register; holds while stalled so res_* stay stable.
  always_comb begin
    res_valid_d = res_valid_q;
    res_d       = res_q;
    if (adv2) begin
      res_valid_d = v1_q;
      if (v1_q) begin
        res_d.z             = s2_z;
        res_d.id            = '0;
        res_d.id[IDW-1:0]   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  // Upper tag bits of the shared record are zero when IDW < MAX_IDW.
  logic [MAX_IDW-1:0] unused_res_id;
  assign unused_res_id = res_q.id;

  assign res_valid = res_valid_q;
  assign res_z     = res_q.z;
  assign res_id    = res_q.id[IDW-1:0];
  assign busy      = v1_q || res_valid_q;

endmodule
